// File: rtl/state_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// state_ctrl_pkg : shared encodings and helpers for the state advance controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package state_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_RUN   = 2'd1;
    localparam logic [1:0] FSM_PAUSE = 2'd2;

    localparam logic [STATE_W-1:0] DEFAULT_LAST_STATE = 3'd7;

    // Out-of-range values are folded onto the last state so they wrap to 0.
    function automatic logic [STATE_W-1:0] advance_state(
        input logic [STATE_W-1:0] cur,
        input logic [STATE_W-1:0] last
    );
        return (cur >= last) ? '0 : cur + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_counter.sv
// ----------------------------------------------------------------------------
// dwell_counter : dwell-time counter with latched length and terminal compare
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dwell_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    input  logic         clear,
    output logic         at_len
);

    logic [W-1:0] cnt;
    logic [W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (load) begin
            cnt   <= '0;
            len_q <= load_val;
        end else if (clear) begin
            cnt   <= '0;
        end else if (enable) begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign at_len = (cnt == len_q);

endmodule

`default_nettype wire

// File: rtl/state_advance_ctrl.sv
// ----------------------------------------------------------------------------
// state_advance_ctrl : drives d of an unreset 3-bit state register, stepping it
// through 0..LAST_STATE with a programmable dwell.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module state_advance_ctrl
    import state_ctrl_pkg::*;
#(
    parameter int                 DWELL_W    = 8,
    parameter logic [STATE_W-1:0] LAST_STATE = DEFAULT_LAST_STATE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hold,
    input  logic               repeat_en,
    input  logic [DWELL_W-1:0] dwell_len,
    input  logic [STATE_W-1:0] q,
    output logic [STATE_W-1:0] d,
    output logic               busy,
    output logic               step,
    output logic               done
);

    logic [1:0] fsm;
    logic [1:0] fsm_nxt;
    logic       at_len;
    logic       advance;
    logic       wrap;

    assign advance = (fsm == FSM_RUN) && !hold && at_len;
    assign wrap    = (q >= LAST_STATE);

    dwell_counter #(
        .W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     ((fsm == FSM_IDLE) && start),
        .load_val (dwell_len),
        .enable   ((fsm == FSM_RUN) && !hold && !at_len),
        .clear    (advance),
        .at_len   (at_len)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= FSM_IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            FSM_IDLE:  if (start) fsm_nxt = FSM_RUN;
            FSM_RUN: begin
                if (hold) begin
                    fsm_nxt = FSM_PAUSE;
                end else if (advance && wrap && !repeat_en) begin
                    fsm_nxt = FSM_IDLE;
                end
            end
            FSM_PAUSE: if (!hold) fsm_nxt = FSM_RUN;
            default:   fsm_nxt = FSM_IDLE;
        endcase
    end

    // Reset overrides d so the unreset state register captures 0 on the same edge.
    always_comb begin
        d    = q;
        busy = 1'b0;
        step = 1'b0;
        done = 1'b0;
        if (reset) begin
            d = '0;
        end else begin
            case (fsm)
                FSM_RUN: begin
                    busy = 1'b1;
                    if (advance) begin
                        step = 1'b1;
                        done = wrap;
                        d    = advance_state(q, LAST_STATE);
                    end
                end
                FSM_PAUSE: busy = 1'b1;
                default:   busy = 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire
